arb_mux_2x1: RTL and testbench

Round-robin packet arbiter that shares one downstream valid/ready channel between two requesters. It drives the select of a 2:1 data mux. The grant is locked for a whole packet, from grant until the beat with last=1 is accepted, so packets never interleave. It sits in front of any single-ported sink, such as a FIFO, UART TX or bus, that two producers must share.

---
 rtl/arb_mux_2x1.sv | 103 ++++++++++
 tb/tb_arb_mux_2x1.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arb_mux_2x1.sv
// arb_mux_2x1: round-robin packet arbiter in front of a 2:1 valid/ready mux.
// A grant is held from the IDLE->GRANT transition until the last beat of the
// packet is accepted, so packets from the two requesters never interleave.
// Optional build macro ARB_STATS_EN adds per-requester completed-packet
// counters (pkt_cnt0/pkt_cnt1, 16 bits, saturating).
module arb_mux_2x1 #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_valid,
  input  logic [DW-1:0] req0_data,
  input  logic          req0_last,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic [DW-1:0] req1_data,
  input  logic          req1_last,
  output logic          req1_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  input  logic          out_ready,
  output logic          sel,
  output logic          busy
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]   pkt_cnt0,
  output logic [15:0]   pkt_cnt1
`endif
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] GRANT0 = 2'd1;
  localparam logic [1:0] GRANT1 = 2'd2;

  logic [1:0] state;
  logic       rr_ptr;   // requester preferred on the next contended arbitration
  logic [1:0] vld;
  logic [1:0] gnt;
  logic [1:0] rdy;
  logic       xfer;
  logic       done;     // last beat of the granted packet accepted this cycle

  assign vld = {req1_valid, req0_valid};
  assign gnt = {state == GRANT1, state == GRANT0};

  // Readys follow out_ready only for the owner; nothing is accepted under reset.
  assign rdy        = rst ? 2'b00 : (gnt & {2{out_ready}});
  assign req0_ready = rdy[0];
  assign req1_ready = rdy[1];

  // out_valid depends on state and requester valid only, never on out_ready.
  assign out_valid = !rst && |(gnt & vld);
  assign out_data  = sel ? req1_data : req0_data;
  assign out_last  = sel ? req1_last : req0_last;
  assign busy      = (state != IDLE);

  assign xfer = out_valid && out_ready;
  assign done = xfer && out_last;

  // Grant FSM: arbitrate in IDLE, hold the grant until the last beat transfers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      rr_ptr <= 1'b0;
      sel    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (vld[0] && (!vld[1] || !rr_ptr)) begin
            state <= GRANT0;
            sel   <= 1'b0;
          end else if (vld[1]) begin
            state <= GRANT1;
            sel   <= 1'b1;
          end
        end
        GRANT0, GRANT1: begin
          // Pointer moves to the requester that did not just finish.
          if (done) begin
            state  <= IDLE;
            rr_ptr <= (state == GRANT0);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ARB_STATS_EN
  // Completed-packet counters, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_cnt0 <= 16'h0000;
      pkt_cnt1 <= 16'h0000;
    end else begin
      if (done && gnt[0] && pkt_cnt0 != 16'hFFFF) pkt_cnt0 <= pkt_cnt0 + 16'd1;
      if (done && gnt[1] && pkt_cnt1 != 16'hFFFF) pkt_cnt1 <= pkt_cnt1 + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_arb_mux_2x1.sv
// Bench for arb_mux_2x1: directed packet streams from two queue-backed
// sources, a cycle-level behavioural model (owner/pointer/select) checked on
// every falling edge, and literal expectations for each scenario.
module tb_arb_mux_2x1;
  typedef struct {
    logic [7:0] d;
    logic       l;
  } beat_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req0_last, req0_ready;
  logic       req1_valid, req1_last, req1_ready;
  logic [7:0] req0_data, req1_data;
  logic       out_valid, out_last, out_ready;
  logic [7:0] out_data;
  logic       sel, busy;
`ifdef ARB_STATS_EN
  logic [15:0] pkt_cnt0, pkt_cnt1;
`endif

  always #5 clk = ~clk;

  arb_mux_2x1 #(.DW(8)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_last(req0_last), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_last(req1_last), .req1_ready(req1_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .sel(sel), .busy(busy)
`ifdef ARB_STATS_EN
    , .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1)
`endif
  );

  int total = 0;
  int bad   = 0;

  beat_t      q0[$], q1[$];
  logic [7:0] xfer_log[$], exp_q[$];
  logic       grant_log[$], exp_g[$];
  logic       en0 = 1'b1, en1 = 1'b1;
  logic       a0, a1;
  logic       chk_en = 1'b0;
  logic       stats_chk = 1'b1;
  logic       prev_busy = 1'b0;

  // Model: -1 = nobody owns the channel, else index of the owner.
  int         own = -1;
  int         ptr = 0;
  logic       sel_m = 1'b0;
  int         m_cnt0 = 0, m_cnt1 = 0;
  logic       ev, ov, ol;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive();
    req0_valid = en0 && (q0.size() != 0);
    req0_data  = (q0.size() != 0) ? q0[0].d : 8'h00;
    req0_last  = (q0.size() != 0) ? q0[0].l : 1'b0;
    req1_valid = en1 && (q1.size() != 0);
    req1_data  = (q1.size() != 0) ? q1[0].d : 8'h00;
    req1_last  = (q1.size() != 0) ? q1[0].l : 1'b0;
    #1;
  endtask

  // One clock: note which source beats get accepted, then advance the sources.
  task automatic tick();
    @(negedge clk);
    a0 = req0_valid && req0_ready;
    a1 = req1_valid && req1_ready;
    @(posedge clk);
    #1;
    if (a0) q0.delete(0);
    if (a1) q1.delete(0);
    drive();
  endtask

  task automatic push0(input logic [7:0] d, input logic l);
    beat_t b;
    b.d = d; b.l = l;
    q0.push_back(b);
  endtask

  task automatic push1(input logic [7:0] d, input logic l);
    beat_t b;
    b.d = d; b.l = l;
    q1.push_back(b);
  endtask

  task automatic chk_log(input string name);
    check({name, "_len"}, xfer_log.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < xfer_log.size(); i++)
      check(name, xfer_log[i], exp_q[i]);
    xfer_log.delete();
  endtask

  task automatic chk_grants(input string name);
    check({name, "_len"}, grant_log.size(), exp_g.size());
    for (int i = 0; i < exp_g.size() && i < grant_log.size(); i++)
      check(name, grant_log[i], exp_g[i]);
    grant_log.delete();
  endtask

  // Behavioural model: who owns the channel, who is preferred next, mux select.
  always @(posedge clk) begin
    if (rst) begin
      own = -1; ptr = 0; sel_m = 1'b0;
      m_cnt0 = 0; m_cnt1 = 0;
    end else if (own < 0) begin
      if (req0_valid && req1_valid) own = ptr;
      else if (req0_valid)          own = 0;
      else if (req1_valid)          own = 1;
      if (own >= 0) sel_m = (own == 1);
    end else begin
      ov = (own == 0) ? req0_valid : req1_valid;
      ol = (own == 0) ? req0_last  : req1_last;
      if (ov && out_ready && ol) begin
        if (own == 0 && m_cnt0 < 65535) m_cnt0++;
        if (own == 1 && m_cnt1 < 65535) m_cnt1++;
        ptr = 1 - own;
        own = -1;
      end
    end
  end

  // Compare DUT against the model every cycle; log transfers and grants.
  always @(negedge clk) begin
    if (chk_en) begin
      ev = !rst && (own >= 0) && ((own == 0) ? req0_valid : req1_valid);
      check("out_valid", out_valid, ev);
      check("req0_ready", req0_ready, !rst && own == 0 && out_ready);
      check("req1_ready", req1_ready, !rst && own == 1 && out_ready);
      check("busy", busy, own >= 0);
      check("sel", sel, sel_m);
      if (ev) begin
        check("out_data", out_data, (own == 0) ? req0_data : req1_data);
        check("out_last", out_last, (own == 0) ? req0_last : req1_last);
      end
`ifdef ARB_STATS_EN
      if (stats_chk) begin
        check("pkt_cnt0", pkt_cnt0, m_cnt0);
        check("pkt_cnt1", pkt_cnt1, m_cnt1);
      end
`endif
      if (out_valid && out_ready) xfer_log.push_back(out_data);
      if (busy && !prev_busy) grant_log.push_back(sel);
      prev_busy = busy;
    end
  end

  initial begin
    rst = 1'b1; out_ready = 1'b0;
    drive();
    tick(); tick();
    chk_en = 1'b1;
    rst = 1'b0;

    // Idle after reset.
    repeat (5) begin
      tick();
      check("idle_valid", out_valid, 1'b0);
      check("idle_busy", busy, 1'b0);
      check("idle_sel", sel, 1'b0);
      check("idle_rdy", {req0_ready, req1_ready}, 2'b00);
    end

    // Lone requester 1 sends AA BB CC.
    out_ready = 1'b1;
    push1(8'hAA, 1'b0); push1(8'hBB, 1'b0); push1(8'hCC, 1'b1);
    drive();
    check("t2_arb_cycle", out_valid, 1'b0);
    tick();
    check("t2_busy", busy, 1'b1);
    check("t2_sel", sel, 1'b1);
    check("t2_d0", out_data, 8'hAA);
    check("t2_r0", req0_ready, 1'b0);
    tick();
    check("t2_d1", out_data, 8'hBB);
    tick();
    check("t2_d2", out_data, 8'hCC);
    check("t2_last", out_last, 1'b1);
    tick();
    check("t2_idle", busy, 1'b0);
    check("t2_sel_hold", sel, 1'b1);
    exp_q = '{8'hAA, 8'hBB, 8'hCC};
    chk_log("t2_data");
    grant_log.delete();

    // Continuous contention with 2-beat packets; pointer is 0 after req1's packet.
    push0(8'h01, 1'b0); push0(8'h02, 1'b1); push0(8'h03, 1'b0); push0(8'h04, 1'b1);
    push1(8'h11, 1'b0); push1(8'h12, 1'b1); push1(8'h13, 1'b0); push1(8'h14, 1'b1);
    drive();
    repeat (12) tick();
    check("t3_end_idle", busy, 1'b0);
    exp_q = '{8'h01, 8'h02, 8'h11, 8'h12, 8'h03, 8'h04, 8'h13, 8'h14};
    chk_log("t3_data");
    exp_g = '{1'b0, 1'b1, 1'b0, 1'b1};
    chk_grants("t3_grant");

    // Owner stalls (out_ready low, then valid low) while req1 waits.
    push0(8'h21, 1'b0); push0(8'h22, 1'b0); push0(8'h23, 1'b1);
    push1(8'h31, 1'b1);
    drive();
    tick();
    check("t4_sel", sel, 1'b0);
    check("t4_r1", req1_ready, 1'b0);
    tick();
    out_ready = 1'b0;
    drive();
    check("t4_r0_low", req0_ready, 1'b0);
    tick();
    out_ready = 1'b1; en0 = 1'b0;
    drive();
    repeat (2) begin
      tick();
      check("t4_hold_busy", busy, 1'b1);
      check("t4_hold_sel", sel, 1'b0);
      check("t4_hold_r1", req1_ready, 1'b0);
    end
    en0 = 1'b1;
    drive();
    repeat (4) tick();
    exp_q = '{8'h21, 8'h22, 8'h23, 8'h31};
    chk_log("t4_data");
    exp_g = '{1'b0, 1'b1};
    chk_grants("t4_grant");

    // Reset in GRANT1 after one of three beats.
    push1(8'h41, 1'b0); push1(8'h42, 1'b0); push1(8'h43, 1'b1);
    drive();
    tick();
    check("t5_sel1", sel, 1'b1);
    tick();
    rst = 1'b1;
    push0(8'h51, 1'b1);
    drive();
    check("t5_rst_valid", out_valid, 1'b0);
    check("t5_rst_rdy", {req0_ready, req1_ready}, 2'b00);
    tick();
    rst = 1'b0;
    drive();
    check("t5_busy", busy, 1'b0);
    check("t5_sel", sel, 1'b0);
    exp_q = '{8'h41};
    chk_log("t5_data");
    tick();
    check("t5_regrant_busy", busy, 1'b1);
    check("t5_regrant_sel", sel, 1'b0);
    check("t5_regrant_d", out_data, 8'h51);
    repeat (5) tick();
    exp_q = '{8'h51, 8'h42, 8'h43};
    chk_log("t5_after");
    grant_log.delete();

`ifdef ARB_STATS_EN
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive();
    check("t6_cnt_rst", pkt_cnt0, 16'h0000);
    push0(8'h61, 1'b1); push0(8'h62, 1'b1); push0(8'h63, 1'b1);
    push1(8'h71, 1'b1);
    drive();
    repeat (10) tick();
    check("t6_cnt0", pkt_cnt0, 16'd3);
    check("t6_cnt1", pkt_cnt1, 16'd1);
    stats_chk = 1'b0;
    force dut.pkt_cnt0 = 16'hFFFE;
    tick();
    release dut.pkt_cnt0;
    m_cnt0 = 16'hFFFE;
    stats_chk = 1'b1;
    push0(8'h81, 1'b1); push0(8'h82, 1'b1); push0(8'h83, 1'b1);
    drive();
    repeat (8) tick();
    check("t6_sat", pkt_cnt0, 16'hFFFF);
    xfer_log.delete();
`endif

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
